// File: rtl/flasher_led_monitor.sv
// flasher_led_monitor: decodes the thermometer-coded LED bus, tracks sweep direction, turns, sweeps and errors.
// Optional stall detector enabled by defining FLASH_MON_STALL_EN.
module flasher_led_monitor #(
    parameter int WIDTH       = 16,
    parameter int LVL_W       = 5,
    parameter int STALL_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] led_in,
    output logic [LVL_W-1:0] level,
    output logic [1:0]       dir,
    output logic             turn,
    output logic [LVL_W-1:0] turn_level,
    output logic [7:0]       sweep_cnt,
    output logic             err_code,
    output logic             err_step,
    output logic             err_any,
    output logic             stall
);
    typedef enum logic [1:0] {IDLE = 2'b00, RISE = 2'b01, FALL = 2'b10, FAULT = 2'b11} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] led_q;
    logic [LVL_W-1:0] level_q, level_d, tl_q, tl_d, new_lvl;
    logic [7:0]       sweep_q, sweep_d;
    logic             turn_q, turn_d, ec_q, ec_d, es_q, es_d, any_q, any_d;
    logic [WIDTH:0]   led_x;
    logic [LVL_W:0]   delta;
    logic             legal, up, dn, jump;

    assign led_x = {1'b0, led_q};
    assign legal = (led_x & (led_x + (WIDTH+1)'(1))) == '0;
    assign delta = {1'b0, new_lvl} - {1'b0, level_q};
    assign up    = delta == (LVL_W+1)'(1);
    assign dn    = delta == '1;
    assign jump  = !(delta == '0 || up || dn);

    // Lit count of the sampled bus; only meaningful when the sample is legal.
    always_comb begin
        new_lvl = '0;
        for (int i = 0; i < WIDTH; i++) new_lvl = new_lvl + LVL_W'(led_q[i]);
    end

    // Direction FSM and per-sample output computation.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        tl_d    = tl_q;
        sweep_d = sweep_q;
        turn_d  = 1'b0;
        ec_d    = 1'b0;
        es_d    = 1'b0;
        if (!legal) begin
            ec_d    = 1'b1;
            state_d = FAULT;
        end else begin
            level_d = new_lvl;
            if (state_q == FAULT) begin
                state_d = (new_lvl == '0) ? IDLE : FAULT;
            end else if (jump) begin
                es_d    = 1'b1;
                state_d = FAULT;
            end else begin
                case (state_q)
                    IDLE: state_d = up ? RISE : IDLE;
                    RISE: if (dn) begin
                        state_d = FALL;
                        turn_d  = 1'b1;
                        tl_d    = level_q;
                    end
                    FALL: if (up) begin
                        state_d = RISE;
                        turn_d  = 1'b1;
                        tl_d    = level_q;
                    end else if (dn && new_lvl == '0) begin
                        state_d = IDLE;
                        sweep_d = (sweep_q == 8'hFF) ? sweep_q : sweep_q + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
        any_d = any_q | ec_d | es_d;
    end

    // Input sample stage and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= '0;
            state_q <= IDLE;
            level_q <= '0;
            tl_q    <= '0;
            sweep_q <= '0;
            turn_q  <= 1'b0;
            ec_q    <= 1'b0;
            es_q    <= 1'b0;
            any_q   <= 1'b0;
        end else begin
            led_q   <= led_in;
            state_q <= state_d;
            level_q <= level_d;
            tl_q    <= tl_d;
            sweep_q <= sweep_d;
            turn_q  <= turn_d;
            ec_q    <= ec_d;
            es_q    <= es_d;
            any_q   <= any_d;
        end
    end

    assign level      = level_q;
    assign dir        = state_q;
    assign turn       = turn_q;
    assign turn_level = tl_q;
    assign sweep_cnt  = sweep_q;
    assign err_code   = ec_q;
    assign err_step   = es_q;
    assign err_any    = any_q;

`ifdef FLASH_MON_STALL_EN
    localparam int HW = $clog2(STALL_LIMIT + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          stall_q, stall_d;
    logic          same;

    assign same = legal && delta == '0 && (state_q == RISE || state_q == FALL);

    // Count unchanged samples while sweeping; freeze at the limit so stall fires once.
    always_comb begin
        hold_d  = same ? hold_q + HW'(hold_q != HW'(STALL_LIMIT)) : '0;
        stall_d = same && hold_q == HW'(STALL_LIMIT - 1);
    end

    // Hold counter and stall pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = (STALL_LIMIT < 0);
`endif
endmodule

// File: tb/tb_flasher_led_monitor.sv
// tb_flasher_led_monitor: directed and random checks of flasher_led_monitor against a behavioural model.
module tb_flasher_led_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] led_in = 16'hFFFF;
    logic [4:0]  level, turn_level;
    logic [1:0]  dir;
    logic [7:0]  sweep_cnt;
    logic        turn, err_code, err_step, err_any, stall;

    int checks = 0;
    int failures = 0;
    int turn_seen = 0, ec_seen = 0, stall_seen = 0;
    int cur = 0;

    flasher_led_monitor dut (
        .clk(clk), .rst(rst), .led_in(led_in), .level(level), .dir(dir), .turn(turn),
        .turn_level(turn_level), .sweep_cnt(sweep_cnt), .err_code(err_code),
        .err_step(err_step), .err_any(err_any), .stall(stall)
    );

    always #5 clk = ~clk;

    // Behavioural model: level as an integer, mode 0 idle / 1 rising / 2 falling / 3 fault.
    int          m_lvl = 0, m_st = 0, m_tl = 0, m_sw = 0, m_hold = 0;
    bit          m_turn = 0, m_ec = 0, m_es = 0, m_any = 0, m_stall = 0;
    logic [15:0] s1 = '0;

    task automatic m_step(input logic [15:0] s);
        int  n = 0, d, prev;
        bit  ok = 0;
        for (int k = 0; k <= 16; k++) if (32'(s) == (1 << k) - 1) begin ok = 1; n = k; end
        m_turn = 0; m_ec = 0; m_es = 0; m_stall = 0;
        prev = m_st;
        if (!ok) begin
            m_ec = 1; m_st = 3; m_hold = 0;
        end else begin
            d = n - m_lvl;
            if (m_st == 3) begin
                if (n == 0) m_st = 0;
            end else if (d > 1 || d < -1) begin
                m_es = 1; m_st = 3;
            end else if (m_st == 0 && d == 1) m_st = 1;
            else if (m_st == 1 && d == -1) begin m_st = 2; m_turn = 1; m_tl = m_lvl; end
            else if (m_st == 2 && d == 1) begin m_st = 1; m_turn = 1; m_tl = m_lvl; end
            else if (m_st == 2 && d == -1 && n == 0) begin m_st = 0; if (m_sw < 255) m_sw++; end
            if ((prev == 1 || prev == 2) && d == 0) begin
                m_hold++;
                if (m_hold == 64) m_stall = 1;
            end else m_hold = 0;
            m_lvl = n;
        end
        m_any = m_any | m_ec | m_es;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lvl = 0; m_st = 0; m_tl = 0; m_sw = 0; m_hold = 0;
            m_turn = 0; m_ec = 0; m_es = 0; m_any = 0; m_stall = 0; s1 = '0;
        end else begin
            m_step(s1);
            s1 = led_in;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus pulse counters for directed checks.
    always @(negedge clk) begin
        chk("level", int'(level), m_lvl);
        chk("dir", int'(dir), m_st);
        chk("turn", int'(turn), int'(m_turn));
        chk("turn_level", int'(turn_level), m_tl);
        chk("sweep_cnt", int'(sweep_cnt), m_sw);
        chk("err_code", int'(err_code), int'(m_ec));
        chk("err_step", int'(err_step), int'(m_es));
        chk("err_any", int'(err_any), int'(m_any));
`ifdef FLASH_MON_STALL_EN
        chk("stall", int'(stall), int'(m_stall));
`else
        chk("stall", int'(stall), 0);
`endif
        turn_seen  += int'(turn);
        ec_seen    += int'(err_code);
        stall_seen += int'(stall);
    end

    function automatic logic [15:0] therm(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    task automatic tick(input logic [15:0] v);
        @(negedge clk);
        #1 led_in = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic settle();
        tick(led_in);
        tick(led_in);
    endtask

    initial begin
        // Reset with all LEDs lit, then release.
        repeat (3) @(negedge clk);
        chk("rst_level", int'(level), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_sweep", int'(sweep_cnt), 0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_e1_err_step", int'(err_step), 0);
        chk("post_rst_e1_dir", int'(dir), 0);
        @(negedge clk);
        chk("post_rst_err_step", int'(err_step), 1);
        chk("post_rst_dir", int'(dir), 3);
        #1 led_in = 16'h0000;
        settle();
        chk("fault_exit_dir", int'(dir), 0);

        // Single 0->5->0 sweep.
        turn_seen = 0;
        for (int n = 1; n <= 5; n++) tick(therm(n));
        for (int n = 4; n >= 0; n--) tick(therm(n));
        settle();
        chk("ramp5_turns", turn_seen, 1);
        chk("ramp5_turn_level", int'(turn_level), 5);
        chk("ramp5_dir", int'(dir), 0);
        chk("ramp5_sweep", int'(sweep_cnt), 1);

        // 256 full sweeps saturate the counter.
        turn_seen = 0;
        for (int r = 0; r < 256; r++) begin
            for (int n = 1; n <= 16; n++) tick(therm(n));
            for (int n = 15; n >= 0; n--) tick(therm(n));
        end
        settle();
        chk("full_turns", turn_seen, 256);
        chk("full_turn_level", int'(turn_level), 16);
        chk("full_sweep_sat", int'(sweep_cnt), 255);

        // Kickback at a trough.
        for (int n = 1; n <= 10; n++) tick(therm(n));
        for (int n = 9; n >= 6; n--) tick(therm(n));
        tick(therm(7));
        tick(therm(8));
        settle();
        chk("kick_turn_level", int'(turn_level), 6);
        chk("kick_dir", int'(dir), 1);

        // Reset mid-sweep clears everything.
        pulse_reset();
        @(negedge clk);
        chk("midrst_sweep", int'(sweep_cnt), 0);
        chk("midrst_err_any", int'(err_any), 0);
        chk("midrst_level", int'(level), 0);
        led_in = 16'h0000;
        settle();

        // Illegal code while rising.
        ec_seen = 0;
        for (int n = 1; n <= 3; n++) tick(therm(n));
        tick(16'h0005);
        tick(therm(4));
        settle();
        chk("illegal_pulses", ec_seen, 1);
        chk("illegal_err_any", int'(err_any), 1);
        chk("illegal_dir", int'(dir), 3);
        chk("illegal_level", int'(level), 4);
        tick(16'h0000);
        settle();
        chk("recover_dir", int'(dir), 0);
        chk("recover_level", int'(level), 0);

        // Hold mid-rise.
        stall_seen = 0;
        for (int n = 1; n <= 6; n++) tick(therm(n));
        repeat (80) tick(16'h003F);
        settle();
`ifdef FLASH_MON_STALL_EN
        chk("stall_once", stall_seen, 1);
`else
        chk("stall_none", stall_seen, 0);
`endif
        for (int n = 5; n >= 0; n--) tick(therm(n));
        settle();

        // Random walk with jumps, illegal codes, holds and one reset.
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(99));
            if (i == 1500) begin
                pulse_reset();
                cur = 0;
                led_in = 16'h0000;
            end
            if (r < 70) begin
                cur += int'($urandom_range(2)) - 1;
                cur = (cur < 0) ? 0 : (cur > 16) ? 16 : cur;
                tick(therm(cur));
            end else if (r < 77) begin
                cur = int'($urandom_range(16));
                tick(therm(cur));
            end else if (r < 85) begin
                cur = 0;
                tick(16'h0000);
            end else if (r < 88) begin
                repeat ($urandom_range(70, 60)) tick(therm(cur));
            end else begin
                tick(16'($urandom));
            end
        end
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
